sym_fir_stream: RTL and testbench

Parametrised, streaming symmetric FIR filter, successor to the fixed 6-coefficient symmetric FIR. Supports odd or even tap counts, a random-access coefficient write port and valid-qualified input/output with fixed latency. Adds rounding/saturation output scaling and a history clear. Sits between the sample source (ADC front-end) and downstream DSP, one sample per clock maximum.

---
 rtl/sym_fir_stream.sv | 146 ++++++++++++++
 tb/tb_sym_fir_stream.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sym_fir_stream.sv
// Streaming symmetric FIR: delay line, pre-add/multiply, adder tree, round/saturate.
// One sample per clock, fixed 4-cycle in_valid -> out_valid latency, no stalls.
module sym_fir_stream #(
    parameter int TAPS        = 12,
    parameter int DATA_WIDTH  = 12,
    parameter int COEFF_WIDTH = 8,
    parameter int OUT_WIDTH   = 16,
    parameter int ROUND_SHIFT = 0,
    parameter int SAT_EN      = 1,
    localparam int NUNIQ      = (TAPS + 1) / 2,
    localparam int AW         = (NUNIQ > 1) ? $clog2(NUNIQ) : 1
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   coeff_we,
    input  logic [AW-1:0]          coeff_addr,
    input  logic [COEFF_WIDTH-1:0] coeff_data,
    input  logic                   hist_clr,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    output logic [OUT_WIDTH-1:0]   out_data
);
    localparam int NPAIR = TAPS / 2;
    localparam int P_W   = DATA_WIDTH + 1;
    localparam int M_W   = P_W + COEFF_WIDTH;
    localparam int ACC_W = M_W + $clog2(NUNIQ);
    localparam int R_W   = ACC_W + 1;
    localparam int E_W   = (R_W > OUT_WIDTH) ? R_W : OUT_WIDTH;

    localparam logic signed [E_W-1:0] MAX_V = {{(E_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [E_W-1:0] MIN_V = {{(E_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0]  x_reg     [TAPS];
    logic signed [COEFF_WIDTH-1:0] coeff_reg [NUNIQ];
    logic signed [P_W-1:0]         pre_add   [NUNIQ];
    logic signed [M_W-1:0]         prod_reg  [NUNIQ];
    logic signed [ACC_W-1:0]       sum_next;
    logic signed [ACC_W-1:0]       sum_reg;
    logic signed [R_W-1:0]         round_val;
    logic signed [E_W-1:0]         round_ext;
    logic [OUT_WIDTH-1:0]          scaled;
    logic                          valid_x_reg;
    logic                          valid_m_reg;
    logic                          valid_s_reg;

    // Delay line; a history clear coincident with a sample keeps only that sample.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < TAPS; i++) x_reg[i] <= '0;
            valid_x_reg <= 1'b0;
        end else begin
            valid_x_reg <= in_valid;
            if (hist_clr) begin
                for (int i = 0; i < TAPS; i++) x_reg[i] <= '0;
                if (in_valid) x_reg[0] <= in_data;
            end else if (in_valid) begin
                x_reg[0] <= in_data;
                for (int i = 1; i < TAPS; i++) x_reg[i] <= x_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NUNIQ; i++) coeff_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUNIQ; i++) begin
                if (coeff_we && coeff_addr == AW'(i)) coeff_reg[i] <= coeff_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUNIQ; gi++) begin : g_pre
            if (gi < NPAIR) begin : g_pair
                assign pre_add[gi] = P_W'(x_reg[gi]) + P_W'(x_reg[TAPS-1-gi]);
            end else begin : g_centre
                assign pre_add[gi] = P_W'(x_reg[gi]);
            end
        end
    endgenerate

    // Coefficients are read here, so a write lands on every window pre-added after its edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NUNIQ; i++) prod_reg[i] <= '0;
            valid_m_reg <= 1'b0;
        end else begin
            valid_m_reg <= valid_x_reg & ~hist_clr;
            for (int i = 0; i < NUNIQ; i++) begin
                prod_reg[i] <= M_W'(pre_add[i]) * M_W'(coeff_reg[i]);
            end
        end
    end

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < NUNIQ; i++) sum_next = sum_next + ACC_W'(prod_reg[i]);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sum_reg     <= '0;
            valid_s_reg <= 1'b0;
        end else begin
            sum_reg     <= sum_next;
            valid_s_reg <= valid_m_reg & ~hist_clr;
        end
    end

    // One guard bit so the rounding offset can never wrap the accumulator.
    generate
        if (ROUND_SHIFT > 0) begin : g_round
            localparam logic signed [R_W-1:0] HALF = R_W'(1) << (ROUND_SHIFT - 1);
            assign round_val = (R_W'(sum_reg) + HALF) >>> ROUND_SHIFT;
        end else begin : g_no_round
            assign round_val = R_W'(sum_reg);
        end
    endgenerate

    assign round_ext = E_W'(round_val);

    always_comb begin
        scaled = round_ext[OUT_WIDTH-1:0];
        if (SAT_EN != 0) begin
            if (round_ext > MAX_V) begin
                scaled = MAX_V[OUT_WIDTH-1:0];
            end else if (round_ext < MIN_V) begin
                scaled = MIN_V[OUT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= valid_s_reg & ~hist_clr;
            if (valid_s_reg && !hist_clr) out_data <= scaled;
        end
    end

endmodule

// File: tb/tb_sym_fir_stream.sv
// Bench for sym_fir_stream: eight parameter sets share one stimulus stream and are
// checked against a direct-convolution reference plus fixed vector tables.
module tb_sym_fir_stream;
    localparam int NCFG = 8;
    localparam int T_P   [NCFG] = '{5, 6, 12, 12, 2, 2, 7, 9};
    localparam int RS_P  [NCFG] = '{0, 0, 0, 0, 2, 0, 3, 1};
    localparam int SAT_P [NCFG] = '{1, 1, 1, 0, 1, 1, 1, 0};
    localparam int OW_P  [NCFG] = '{16, 16, 16, 16, 16, 16, 10, 12};

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic [NCFG-1:0]  coeff_we = '0;
    logic [2:0]       coeff_addr = '0;
    logic [7:0]       coeff_data = '0;
    logic             hist_clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [11:0]      in_data = '0;
    logic [NCFG-1:0]  out_valid;
    logic signed [15:0] out_ext [NCFG];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_dut
            localparam int NU  = (T_P[gi] + 1) / 2;
            localparam int AWI = (NU > 1) ? $clog2(NU) : 1;
            logic [AWI-1:0]       addr_slice;
            logic [OW_P[gi]-1:0]  od;
            assign addr_slice = coeff_addr[AWI-1:0];
            sym_fir_stream #(
                .TAPS(T_P[gi]), .DATA_WIDTH(12), .COEFF_WIDTH(8), .OUT_WIDTH(OW_P[gi]),
                .ROUND_SHIFT(RS_P[gi]), .SAT_EN(SAT_P[gi])
            ) u_dut (
                .clk(clk), .clr(clr), .coeff_we(coeff_we[gi]), .coeff_addr(addr_slice),
                .coeff_data(coeff_data), .hist_clr(hist_clr), .in_valid(in_valid),
                .in_data(in_data), .out_valid(out_valid[gi]), .out_data(od)
            );
            assign out_ext[gi] = 16'(signed'(od));
        end
    endgenerate

    // Reference state: full window, coefficient table, and expected outputs queued by edge.
    longint mx [NCFG][12];
    longint mc [NCFG][6];
    bit     pv [NCFG][4];
    longint pd [NCFG][4];
    bit     ev [NCFG];
    longint ed [NCFG];

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCFG; c++) begin
            for (int j = 0; j < 12; j++) mx[c][j] = 0;
            for (int j = 0; j < 6; j++) mc[c][j] = 0;
            for (int j = 0; j < 4; j++) begin pv[c][j] = 0; pd[c][j] = 0; end
            ev[c] = 0;
            ed[c] = 0;
        end
    endfunction

    // Plain convolution with mirrored coefficients, then round and clamp/wrap.
    function automatic longint model_out(int c);
        longint acc = 0;
        longint hi, lo, span;
        int t = T_P[c];
        int ow = OW_P[c];
        for (int j = 0; j < t; j++) begin
            int k = (j < t - 1 - j) ? j : t - 1 - j;
            acc += mx[c][j] * mc[c][k];
        end
        if (RS_P[c] > 0) acc = (acc + (longint'(1) << (RS_P[c] - 1))) >>> RS_P[c];
        span = longint'(1) << ow;
        hi = (span / 2) - 1;
        lo = -(span / 2);
        if (SAT_P[c] != 0) begin
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
        end else begin
            acc = acc & (span - 1);
            if (acc > hi) acc -= span;
        end
        return acc;
    endfunction

    task automatic model_edge();
        if (clr) return;
        for (int c = 0; c < NCFG; c++) begin
            int t = T_P[c];
            int nu = (t + 1) / 2;
            int aw = (nu > 1) ? $clog2(nu) : 1;
            int idx = int'(coeff_addr) & ((1 << aw) - 1);
            if (coeff_we[c] && idx < nu) mc[c][idx] = longint'($signed(coeff_data));
            if (hist_clr) begin
                for (int j = 0; j < t; j++) mx[c][j] = 0;
                for (int j = 1; j < 4; j++) pv[c][j] = 0;
            end
            if (in_valid) begin
                for (int j = t - 1; j > 0; j--) mx[c][j] = mx[c][j-1];
                mx[c][0] = longint'($signed(in_data));
            end
            ev[c] = pv[c][1];
            if (pv[c][1]) ed[c] = pd[c][1];
            pv[c][1] = pv[c][2]; pd[c][1] = pd[c][2];
            pv[c][2] = pv[c][3]; pd[c][2] = pd[c][3];
            pv[c][3] = in_valid;
            pd[c][3] = in_valid ? model_out(c) : 0;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCFG; c++) begin
            chk($sformatf("cfg%0d_valid", c), longint'(out_valid[c]), longint'(ev[c]));
            chk($sformatf("cfg%0d_data", c), longint'(out_ext[c]), ed[c]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        coeff_we = '0; hist_clr = 1'b0; in_valid = 1'b0; in_data = '0;
    endtask

    task automatic random_phase(int n);
        for (int i = 0; i < n; i++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            in_data    = 12'($urandom);
            coeff_we   = ($urandom_range(0, 9) == 0) ? NCFG'($urandom) : '0;
            coeff_addr = 3'($urandom);
            coeff_data = 8'($urandom);
            hist_clr   = ($urandom_range(0, 29) == 0);
            tick();
        end
        idle();
    endtask

    typedef struct {
        logic        hc;
        logic        vin;
        logic [11:0] din;
        logic        exp_v;
        int          e0;
        int          e1;
    } vec_t;

    vec_t       vecs[$];
    longint     got[$];
    int         rnd_seq[6] = '{3, 3, -3, -3, 2, 3};
    longint     rnd_exp[6] = '{1, 2, 0, -1, 0, 1};

    initial begin
        // Impulse responses: TAPS=5 -> 1,2,3,2,1,0 and TAPS=6 -> 1,2,3,3,2,1,0.
        vecs.push_back('{1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 1});
        vecs.push_back('{0, 1, 0, 1, 2, 2});
        vecs.push_back('{0, 1, 0, 1, 3, 3});
        vecs.push_back('{0, 1, 0, 1, 2, 3});
        vecs.push_back('{0, 1, 0, 1, 1, 2});
        vecs.push_back('{0, 1, 0, 1, 0, 1});
        vecs.push_back('{0, 1, 0, 1, 0, 0});
        // Same impulse with in_valid toggling: gaps must reappear on out_valid.
        vecs.push_back('{1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 1, 1});
        vecs.push_back('{0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 2, 2});
        vecs.push_back('{0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 3, 3});
        vecs.push_back('{0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 2, 3});
        vecs.push_back('{0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 1, 2});
        vecs.push_back('{0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 0});

        model_reset();
        tick();
        tick();
        clr = 1'b0;

        random_phase(300);

        for (int a = 0; a < 3; a++) begin
            coeff_we = NCFG'(8'h03); coeff_addr = 3'(a); coeff_data = 8'(a + 1);
            tick();
        end
        idle();

        foreach (vecs[i]) begin
            hist_clr = vecs[i].hc; in_valid = vecs[i].vin; in_data = vecs[i].din;
            tick();
            chk($sformatf("tbl%0d_valid5", i), longint'(out_valid[0]), longint'(vecs[i].exp_v));
            chk($sformatf("tbl%0d_valid6", i), longint'(out_valid[1]), longint'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                chk($sformatf("tbl%0d_data5", i), longint'(out_ext[0]), longint'(vecs[i].e0));
                chk($sformatf("tbl%0d_data6", i), longint'(out_ext[1]), longint'(vecs[i].e1));
            end
        end
        idle();

        // Full-scale window: saturating vs wrapping 16-bit output.
        for (int a = 0; a < 6; a++) begin
            coeff_we = NCFG'(8'h0C); coeff_addr = 3'(a); coeff_data = 8'sd127;
            tick();
        end
        idle();
        hist_clr = 1'b1; tick(); idle();
        for (int i = 0; i < 16; i++) begin in_valid = 1'b1; in_data = 12'sd2047; tick(); end
        chk("sat_pos", longint'(out_ext[2]), 32767);
        chk("wrap_pos", longint'(out_ext[3]), -26100);
        for (int i = 0; i < 16; i++) begin in_valid = 1'b1; in_data = 12'h800; tick(); end
        chk("sat_neg", longint'(out_ext[2]), -32768);
        chk("wrap_neg", longint'(out_ext[3]), 24576);
        idle();

        // Round-half-up by 2 on TAPS=2 sums 3,6,0,-6,-1,5.
        coeff_we = NCFG'(8'h30); coeff_addr = 3'd0; coeff_data = 8'd1; hist_clr = 1'b1;
        tick(); idle();
        got.delete();
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 6);
            in_data  = (i < 6) ? 12'(rnd_seq[i]) : 12'd0;
            tick();
            if (out_valid[4]) got.push_back(longint'(out_ext[4]));
        end
        idle();
        chk("round_count", longint'(got.size()), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("round%0d", i), got[i], rnd_exp[i]);

        // Coefficient rewrite under constant input 10: output steps 20 -> 80.
        hist_clr = 1'b1; tick(); idle();
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = 12'd10;
            coeff_we = (i == 5) ? NCFG'(8'h20) : '0; coeff_addr = 3'd0; coeff_data = 8'd4;
            tick();
            if (i == 7) chk("rewrite_before", longint'(out_ext[5]), 20);
            if (i == 8) chk("rewrite_after", longint'(out_ext[5]), 80);
            if (i >= 7) chk($sformatf("rewrite_valid%0d", i), longint'(out_valid[5]), 1);
        end
        idle();

        // Asynchronous reset in mid-cycle with samples in flight.
        for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = 12'($urandom); tick(); end
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        chk("clr_async_valid", longint'(out_valid[2]), 0);
        chk("clr_async_data", longint'(out_ext[2]), 0);
        tick();
        tick();
        #2;
        clr = 1'b0;
        in_valid = 1'b1; in_data = 12'd1; tick();
        in_data = 12'd0;
        for (int i = 0; i < 3; i++) tick();
        chk("clr_zero_coeff_valid", longint'(out_valid[0]), 1);
        chk("clr_zero_coeff_data", longint'(out_ext[0]), 0);
        idle();

        random_phase(250);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
